// File: rtl/wb_queue_if.sv
// wb_queue_if: bundles the two producer result paths, the back-pressure and
// overflow flags, and the register-file write port of the writeback queue.
// The bypass lookup signals are present only when WB_QUEUE_BYPASS_EN is defined.
interface wb_queue_if;
  logic        mem_valid;
  logic [2:0]  mem_regsel;
  logic [15:0] mem_data;
  logic        alu_valid;
  logic [2:0]  alu_regsel;
  logic [15:0] alu_data;
  logic        stall;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        err;
`ifdef WB_QUEUE_BYPASS_EN
  logic [2:0]  byp1sel;
  logic [2:0]  byp2sel;
  logic        byp1hit;
  logic        byp2hit;
  logic [15:0] byp1data;
  logic [15:0] byp2data;

  // Producer / decode side.
  modport master (
    output mem_valid, mem_regsel, mem_data, alu_valid, alu_regsel, alu_data,
    output byp1sel, byp2sel,
    input  stall, write, writeregsel, writedata, err,
    input  byp1hit, byp2hit, byp1data, byp2data
  );

  // Queue side.
  modport slave (
    input  mem_valid, mem_regsel, mem_data, alu_valid, alu_regsel, alu_data,
    input  byp1sel, byp2sel,
    output stall, write, writeregsel, writedata, err,
    output byp1hit, byp2hit, byp1data, byp2data
  );
`else
  // Producer side.
  modport master (
    output mem_valid, mem_regsel, mem_data, alu_valid, alu_regsel, alu_data,
    input  stall, write, writeregsel, writedata, err
  );

  // Queue side.
  modport slave (
    input  mem_valid, mem_regsel, mem_data, alu_valid, alu_regsel, alu_data,
    output stall, write, writeregsel, writedata, err
  );
`endif
endinterface

// File: rtl/wb_queue.sv
// wb_queue: writeback staging queue in front of the 8x16 register file.
// Takes up to two results per cycle (load result older than ALU result),
// keeps them in program order in a circular buffer and retires one per cycle.
// Optional pending-write bypass lookup: define WB_QUEUE_BYPASS_EN.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  wb_queue_if.slave bus
);

  logic [2:0]       r_regsel [DEPTH];
  logic [15:0]      r_data   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_err;

  logic             w_stall;
  logic             w_memEn;
  logic             w_aluEn;
  logic             w_deq;
  logic [PTR_W:0]   w_enqN;
  logic [PTR_W:0]   w_deqN;
  logic [PTR_W-1:0] w_aluIdx;

  // Stalling one entry early leaves room for a dual enqueue in any state.
  assign w_stall  = (r_count >= (PTR_W+1)'(DEPTH - 1));
  assign w_memEn  = bus.mem_valid & ~w_stall;
  assign w_aluEn  = bus.alu_valid & ~w_stall;
  assign w_enqN   = (PTR_W+1)'(w_memEn) + (PTR_W+1)'(w_aluEn);
  assign w_deq    = (r_count != '0);
  assign w_deqN   = (PTR_W+1)'(w_deq);
  assign w_aluIdx = w_memEn ? r_tail + PTR_W'(1) : r_tail;

  // Entry storage: the load result lands at tail, the ALU result right behind it.
  // No reset is needed here because every reader is gated by the live count.
  always_ff @(posedge clk) begin
    if (w_memEn) begin
      r_regsel[r_tail] <= bus.mem_regsel;
      r_data[r_tail]   <= bus.mem_data;
    end
    if (w_aluEn) begin
      r_regsel[w_aluIdx] <= bus.alu_regsel;
      r_data[w_aluIdx]   <= bus.alu_data;
    end
  end

  // Pointer, occupancy and overflow-pulse bookkeeping; reset discards everything pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + w_enqN[PTR_W-1:0];
      r_count <= r_count + w_enqN - w_deqN;
      r_err   <= (bus.mem_valid | bus.alu_valid) & w_stall;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.err         = r_err;
  assign bus.write       = w_deq;
  assign bus.writeregsel = w_deq ? r_regsel[r_head] : 3'd0;
  assign bus.writedata   = w_deq ? r_data[r_head]   : 16'd0;

`ifdef WB_QUEUE_BYPASS_EN
  logic        w_byp1Hit;
  logic        w_byp2Hit;
  logic [15:0] w_byp1Data;
  logic [15:0] w_byp2Data;

  // Scan live entries oldest to youngest so the last match is the youngest writer.
  always_comb begin
    w_byp1Hit  = 1'b0;
    w_byp2Hit  = 1'b0;
    w_byp1Data = 16'd0;
    w_byp2Data = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < r_count) begin
        if (r_regsel[r_head + PTR_W'(i)] == bus.byp1sel) begin
          w_byp1Hit  = 1'b1;
          w_byp1Data = r_data[r_head + PTR_W'(i)];
        end
        if (r_regsel[r_head + PTR_W'(i)] == bus.byp2sel) begin
          w_byp2Hit  = 1'b1;
          w_byp2Data = r_data[r_head + PTR_W'(i)];
        end
      end
    end
  end

  assign bus.byp1hit  = w_byp1Hit;
  assign bus.byp2hit  = w_byp2Hit;
  assign bus.byp1data = w_byp1Data;
  assign bus.byp2data = w_byp2Data;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed, table-driven bench for wb_queue (DEPTH=4), plus
// hand-written reset, overflow and (with WB_QUEUE_BYPASS_EN) bypass sequences.
module tb_wb_queue;

  typedef struct {
    logic        memValid;
    logic [2:0]  memSel;
    logic [15:0] memData;
    logic        aluValid;
    logic [2:0]  aluSel;
    logic [15:0] aluData;
    logic        expStall;
    logic        expWrite;
    logic [2:0]  expSel;
    logic [15:0] expData;
    logic        expErr;
  } vec_t;

  localparam int NVEC = 19;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [NVEC];

  wb_queue_if bus();

  wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic eStall, input logic eWrite,
                            input logic [2:0] eSel, input logic [15:0] eData, input logic eErr);
    checkOutput({tag, ".stall"},       16'(bus.stall),       16'(eStall));
    checkOutput({tag, ".write"},       16'(bus.write),       16'(eWrite));
    checkOutput({tag, ".writeregsel"}, 16'(bus.writeregsel), 16'(eSel));
    checkOutput({tag, ".writedata"},   bus.writedata,        eData);
    checkOutput({tag, ".err"},         16'(bus.err),         16'(eErr));
  endtask

  task automatic applyStimulus(input logic mv, input logic [2:0] ms, input logic [15:0] md,
                               input logic av, input logic [2:0] aSel, input logic [15:0] ad);
    bus.mem_valid  = mv;
    bus.mem_regsel = ms;
    bus.mem_data   = md;
    bus.alu_valid  = av;
    bus.alu_regsel = aSel;
    bus.alu_data   = ad;
  endtask

  task automatic stepCycle(input logic mv, input logic [2:0] ms, input logic [15:0] md,
                           input logic av, input logic [2:0] aSel, input logic [15:0] ad);
    applyStimulus(mv, ms, md, av, aSel, ad);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for one edge, then outputs expected just after that edge.
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h5555, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202, 1'b0, 1'b1, 3'd1, 16'h0101, 1'b0};
    vecs[7]  = '{1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404, 1'b1, 1'b1, 3'd2, 16'h0202, 1'b0};
    vecs[8]  = '{1'b1, 3'd5, 16'h0505, 1'b1, 3'd6, 16'h0606, 1'b0, 1'b1, 3'd3, 16'h0303, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h0404, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 3'd1, 16'h1111, 1'b0};
    vecs[14] = '{1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h4444, 1'b1, 1'b1, 3'd2, 16'h2222, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 3'd3, 16'h3333, 1'b1};
    vecs[16] = '{1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h4444, 1'b0};
    vecs[17] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h5555, 1'b0};
    vecs[18] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};

    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef WB_QUEUE_BYPASS_EN
    bus.byp1sel = 3'd0;
    bus.byp2sel = 3'd0;
`endif

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table: single path, dual ordering, back-pressure with wrap, drop under stall.
    for (int i = 0; i < NVEC; i++) begin
      stepCycle(vecs[i].memValid, vecs[i].memSel, vecs[i].memData,
                vecs[i].aluValid, vecs[i].aluSel, vecs[i].aluData);
      checkState($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expWrite,
                 vecs[i].expSel, vecs[i].expData, vecs[i].expErr);
    end

    // Asynchronous reset with three entries pending.
    stepCycle(1'b1, 3'd1, 16'h0A01, 1'b1, 3'd2, 16'h0A02);
    stepCycle(1'b1, 3'd3, 16'h0A03, 1'b1, 3'd4, 16'h0A04);
    checkOutput("rstSeq.stallBefore", 16'(bus.stall), 16'h0001);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    checkState("rstSeq.during", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkState("rstSeq.after", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    stepCycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h6666);
    checkState("rstSeq.fresh", 1'b0, 1'b1, 3'd6, 16'h6666, 1'b0);
    stepCycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkState("rstSeq.drained", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);

    // Overflow pulse cleared asynchronously by reset.
    stepCycle(1'b1, 3'd1, 16'h0B01, 1'b1, 3'd2, 16'h0B02);
    stepCycle(1'b1, 3'd3, 16'h0B03, 1'b1, 3'd4, 16'h0B04);
    stepCycle(1'b1, 3'd7, 16'h0B07, 1'b0, 3'd0, 16'h0);
    checkOutput("errSeq.pulse", 16'(bus.err), 16'h0001);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("errSeq.cleared", 16'(bus.err), 16'h0000);
    checkOutput("errSeq.write", 16'(bus.write), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    stepCycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkState("errSeq.after", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);

`ifdef WB_QUEUE_BYPASS_EN
    // Bypass: youngest match wins, same-cycle inputs ignored, drained entries ignored.
    bus.byp1sel = 3'd5;
    bus.byp2sel = 3'd6;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0BAD);
    #1;
    checkOutput("byp.sameCycleHit", 16'(bus.byp2hit), 16'h0000);
    stepCycle(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002);
    checkOutput("byp.b1hit", 16'(bus.byp1hit), 16'h0001);
    checkOutput("byp.b1data", bus.byp1data, 16'h0002);
    checkOutput("byp.b2hit", 16'(bus.byp2hit), 16'h0000);
    checkOutput("byp.b2data", bus.byp2data, 16'h0000);
    checkOutput("byp.writedata", bus.writedata, 16'h0001);
    stepCycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkOutput("byp.oneLeftHit", 16'(bus.byp1hit), 16'h0001);
    checkOutput("byp.oneLeftData", bus.byp1data, 16'h0002);
    stepCycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkOutput("byp.drainedHit", 16'(bus.byp1hit), 16'h0000);
    checkOutput("byp.drainedData", bus.byp1data, 16'h0000);
    stepCycle(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0);
    checkOutput("byp.b2hitLive", 16'(bus.byp2hit), 16'h0001);
    checkOutput("byp.b2dataLive", bus.byp2data, 16'h0066);
    checkOutput("byp.b1missLive", 16'(bus.byp1hit), 16'h0000);
    stepCycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
